uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 0, meaning idle clocks inserted after each byte completes, before the next byte is offered (0..255).
REQ-002 Parameter BUSY_TIMEOUT, default 4, meaning max clocks to wait for tx_busy to rise after tx_en (1..255).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  4  per-requester byte-valid.
REQ-006 req_data  input  32  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 req_last  input  4  per-requester end-of-packet flag, qualified by req_valid.
REQ-008 req_ready  output  4  per-requester byte-accept strobe.
REQ-009 grant  output  4  one-hot current packet owner, all-zero when none.
REQ-010 tx_data  output  8  byte to transmitter.
REQ-011 tx_en  output  1  one-cycle start strobe to transmitter.
REQ-012 tx_busy  input  1  transmitter busy, high from the cycle after tx_en until the frame ends.
REQ-013 tx_err  output  1  one-cycle pulse on busy timeout.

Function
REQ-014 States SHALL be IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP; encoding free.
REQ-015 IDLE: when any req_valid is high, the block SHALL register a one-hot winner into grant and enter SEND next cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at index (last_owner+1) mod 4, ascending with wrap; last_owner resets to 3, so requester 0 has first priority.
REQ-017 Arbitration SHALL occur only in IDLE; grant SHALL hold constant from SEND entry until the last byte of the packet completes.
REQ-018 req_ready SHALL be combinational: req_ready[i] = (state==SEND) & grant[i]; a byte transfers when req_valid[i] & req_ready[i].
REQ-019 SEND with owner req_valid low SHALL remain in SEND, grant held, no timeout.
REQ-020 On transfer: tx_data SHALL load req_data of the owner, the last flag SHALL be latched, tx_en SHALL be high exactly the following cycle, and state SHALL go to WAIT_BUSY.
REQ-021 tx_data SHALL hold its value until the next transfer.
REQ-022 WAIT_BUSY: tx_busy high -> WAIT_DONE. If tx_busy stays low for BUSY_TIMEOUT cycles after tx_en, the block SHALL pulse tx_err for one cycle and treat the byte as completed.
REQ-023 WAIT_DONE: tx_busy low -> GAP if GAP_CYCLES>0, else directly to the completion decision.
REQ-024 GAP SHALL last exactly GAP_CYCLES clocks, then go to the completion decision.
REQ-025 Completion decision: latched last=1 -> IDLE, grant cleared, last_owner updated to the owner. Latched last=0 -> SEND with the same owner.
REQ-026 A request from a non-owner SHALL never be accepted while grant is nonzero; its req_valid may stay high indefinitely.
REQ-027 Requesters that drop req_valid before being granted SHALL lose nothing; there is no request latching.
REQ-028 At most one req_ready bit SHALL be high in any cycle, and grant SHALL always be one-hot or zero.
REQ-029 Internal counters SHALL be sized by $clog2 of their parameter plus 1 and SHALL saturate, never wrap.

Reset
REQ-030 While rst_n is low: state=IDLE, grant=0, req_ready=0, tx_en=0, tx_data=8'h00, tx_err=0, last_owner=3, counters=0.
REQ-031 Reset asserted mid-packet SHALL abort immediately, with no further tx_en. After release, the first arbitration SHALL restart at requester 0.

Verification
REQ-032 Single byte: valid[2]=1, data=8'h5A, last=1, tx_busy high 1 cycle after tx_en for 10 cycles -> one tx_en, tx_data=8'h5A, grant=4'b0100 until busy falls, then IDLE.
REQ-033 Round-robin: all four valid, single-byte packets, held high -> grant order 0,1,2,3,0.
REQ-034 Packet lock: requester 1 sends 3 bytes (last on third) while requester 0 is valid -> requester 0 gets no req_ready until requester 1's third byte completes, then is granted.
REQ-035 Gap: GAP_CYCLES=3, two-byte packet -> exactly 3 idle clocks between first busy fall and second req_ready.
REQ-036 Timeout: tx_busy held 0, BUSY_TIMEOUT=4 -> tx_err pulses once 4 cycles after tx_en, and the arbiter proceeds to the next byte or IDLE.
REQ-037 Reset in WAIT_DONE -> all outputs at REQ-030 values within the same cycle. Next grant with all requesters valid = 4'b0001.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter that feeds one byte at a
// time from four requesters into a single UART transmitter.
// A byte is accepted from the owner, strobed out with tx_en, and tracked
// through the transmitter busy window (with a busy-rise timeout). An optional
// idle gap follows. The owner keeps the grant until the byte flagged as last
// completes; the next arbitration then starts after that owner.

module uart_tx_arbiter #(
   parameter int GAP_CYCLES   = 0,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_last,
   output logic [3:0]  req_ready,
   output logic [3:0]  grant,
   output logic [7:0]  tx_data,
   output logic        tx_en,
   input  logic        tx_busy,
   output logic        tx_err
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

   // Counter widths and terminal values. The busy counter counts every
   // WAIT_BUSY cycle, starting at 0 in the tx_en cycle, so it reaches
   // BUSY_TIMEOUT-1 in the last cycle that is still allowed to see busy rise.
   localparam int BUSY_W = $clog2(BUSY_TIMEOUT) + 1;
   localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
   localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_TIMEOUT - 1);
   localparam logic [BUSY_W-1:0] BUSY_MAX  = {BUSY_W{1'b1}};
   localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0]  GAP_MAX   = {GAP_W{1'b1}};
   localparam logic              HAS_GAP   = (GAP_CYCLES > 0);

   // Round-robin pick: search starts at last+1 and wraps; at most one bit set.
   function automatic logic [3:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
      logic [3:0] pick;
      logic       found;
      logic [1:0] idx;
      pick  = 4'b0000;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + k[1:0];
         if (valid[idx] && !found) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      return pick;
   endfunction

   // Index of a one-hot owner vector (grant is never multi-hot).
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      case (oh)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   state_t            decide_state_s;
   state_t            after_byte_s;
   logic [3:0]        grant_r;
   logic [1:0]        last_owner_r;
   logic [7:0]        tx_data_r;
   logic              tx_en_r;
   logic              tx_err_r;
   logic              last_r;
   logic [BUSY_W-1:0] busy_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic [3:0]        req_ready_s;
   logic [7:0]        owner_data_s;
   logic              owner_last_s;
   logic              xfer_s;
   logic              timeout_s;
   logic              byte_done_s;
   logic              gap_end_s;
   logic              decide_s;
   logic              release_s;

   assign xfer_s      = (state_r == ST_SEND) & (|(req_valid & grant_r));
   assign timeout_s   = (state_r == ST_WAIT_BUSY) & ~tx_busy & (busy_cnt_r == BUSY_LAST);
   assign byte_done_s = timeout_s | ((state_r == ST_WAIT_DONE) & ~tx_busy);
   assign gap_end_s   = (state_r == ST_GAP) & (gap_cnt_r == GAP_LAST);
   assign decide_s    = (byte_done_s & ~HAS_GAP) | gap_end_s;
   assign release_s   = decide_s & last_r;

   // Select the owner's byte and last flag by AND-OR over the one-hot grant.
   always_comb begin
      owner_data_s = 8'h00;
      owner_last_s = 1'b0;
      for (int k = 0; k < 4; k++) begin
         owner_data_s = owner_data_s | (req_data[8*k +: 8] & {8{grant_r[k]}});
         owner_last_s = owner_last_s | (req_last[k] & grant_r[k]);
      end
   end

   // Where a completed byte leads: straight to the completion decision or via the gap.
   always_comb begin
      decide_state_s = ST_SEND;
      after_byte_s   = ST_GAP;
      if (last_r) begin
         decide_state_s = ST_IDLE;
      end else begin
         decide_state_s = ST_SEND;
      end
      if (HAS_GAP) begin
         after_byte_s = ST_GAP;
      end else begin
         after_byte_s = decide_state_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (|req_valid) state_nxt_s = ST_SEND;
            else            state_nxt_s = ST_IDLE;
         end
         ST_SEND: begin
            if (xfer_s) state_nxt_s = ST_WAIT_BUSY;
            else        state_nxt_s = ST_SEND;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy)        state_nxt_s = ST_WAIT_DONE;
            else if (timeout_s) state_nxt_s = after_byte_s;
            else                state_nxt_s = ST_WAIT_BUSY;
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) state_nxt_s = after_byte_s;
            else          state_nxt_s = ST_WAIT_DONE;
         end
         ST_GAP: begin
            if (gap_end_s) state_nxt_s = decide_state_s;
            else           state_nxt_s = ST_GAP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output logic: only the owner sees ready, and only while in SEND.
   always_comb begin
      req_ready_s = 4'b0000;
      if (state_r == ST_SEND) begin
         req_ready_s = grant_r;
      end else begin
         req_ready_s = 4'b0000;
      end
   end

   // Grant and round-robin pointer: arbitrate only in IDLE, release on packet end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_r      <= 4'b0000;
         last_owner_r <= 2'd3;
      end else if (state_r == ST_IDLE) begin
         grant_r <= rr_pick(req_valid, last_owner_r);
      end else if (release_s) begin
         grant_r      <= 4'b0000;
         last_owner_r <= onehot_to_idx(grant_r);
      end else begin
         grant_r <= grant_r;
      end
   end

   // Transmit datapath: capture the accepted byte and its last flag, strobe tx_en/tx_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data_r <= 8'h00;
         last_r    <= 1'b0;
         tx_en_r   <= 1'b0;
         tx_err_r  <= 1'b0;
      end else begin
         tx_en_r  <= xfer_s;
         tx_err_r <= timeout_s;
         if (xfer_s) begin
            tx_data_r <= owner_data_s;
            last_r    <= owner_last_s;
         end
      end
   end

   // Busy-rise watchdog: cleared on each accepted byte, counts WAIT_BUSY cycles, saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt_r <= {BUSY_W{1'b0}};
      end else if (xfer_s) begin
         busy_cnt_r <= {BUSY_W{1'b0}};
      end else if ((state_r == ST_WAIT_BUSY) && !tx_busy && (busy_cnt_r != BUSY_MAX)) begin
         busy_cnt_r <= busy_cnt_r + BUSY_W'(1);
      end else begin
         busy_cnt_r <= busy_cnt_r;
      end
   end

   // Inter-byte gap timer: zero outside GAP, counts up inside it, saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt_r <= {GAP_W{1'b0}};
      end else if (state_r != ST_GAP) begin
         gap_cnt_r <= {GAP_W{1'b0}};
      end else if (gap_cnt_r != GAP_MAX) begin
         gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

   assign req_ready = req_ready_s;
   assign grant     = grant_r;
   assign tx_data   = tx_data_r;
   assign tx_en     = tx_en_r;
   assign tx_err    = tx_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a default instance (no gap, timeout 4)
// and a GAP_CYCLES=3 instance, simple per-requester byte queues and a
// transmitter model that holds busy for busy_len cycles after each tx_en.

module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready, grant;
   logic [7:0]  tx_data;
   logic        tx_en, tx_busy, tx_err;
   logic [3:0]  g_req_ready, g_grant;
   logic [7:0]  g_tx_data;
   logic        g_tx_en, g_tx_busy, g_tx_err;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int busy_len = 2;
   int busy_left, g_busy_left;

   logic [7:0] q_data [4][8];
   logic       q_last [4][8];
   int         q_len  [4];
   int         q_ptr  [4];
   logic [3:0] stall = 4'b0000;
   logic       sel_g = 1'b0;

   int         en_cyc [$];
   logic [3:0] en_gnt [$];
   logic [7:0] en_dat [$];
   int         err_cyc [$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.GAP_CYCLES(0), .BUSY_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
      .tx_en(tx_en), .tx_busy(tx_busy), .tx_err(tx_err));

   uart_tx_arbiter #(.GAP_CYCLES(3), .BUSY_TIMEOUT(4)) dut_g (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(g_req_ready), .grant(g_grant), .tx_data(g_tx_data),
      .tx_en(g_tx_en), .tx_busy(g_tx_busy), .tx_err(g_tx_err));

   // Transmitter models: busy from the cycle after tx_en for busy_len cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             busy_left <= 0;
      else if (tx_en)         busy_left <= busy_len;
      else if (busy_left > 0) busy_left <= busy_left - 1;
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               g_busy_left <= 0;
      else if (g_tx_en)         g_busy_left <= busy_len;
      else if (g_busy_left > 0) g_busy_left <= g_busy_left - 1;
   end
   assign tx_busy   = (busy_left != 0);
   assign g_tx_busy = (g_busy_left != 0);

   // Event log of the default instance.
   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_en) begin
            en_cyc.push_back(cyc);
            en_gnt.push_back(grant);
            en_dat.push_back(tx_data);
         end
         if (tx_err) err_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         if (q_ptr[i] < q_len[i] && !stall[i]) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = q_data[i][q_ptr[i]];
            req_last[i]        = q_last[i][q_ptr[i]];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic load(input int i, input logic [7:0] d, input logic l);
      q_data[i][q_len[i]] = d;
      q_last[i][q_len[i]] = l;
      q_len[i]++;
   endtask

   task automatic step();
      logic [3:0] fire;
      fire = req_valid & (sel_g ? g_req_ready : req_ready);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) if (fire[i]) q_ptr[i]++;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stall = 4'b0000;
      sel_g = 1'b0;
      for (int i = 0; i < 4; i++) begin q_len[i] = 0; q_ptr[i] = 0; end
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      en_cyc.delete(); en_gnt.delete(); en_dat.delete(); err_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin q_len[i] = 0; q_ptr[i] = 0; load(i, 8'hFF, 1'b1); end
      drive();
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b, expected 0000", grant); end
      n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b, expected 0000", req_ready); end
      n_vec++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL reset_tx_en: got %b, expected 0", tx_en); end
      n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h, expected 00", tx_data); end
      n_vec++; if (tx_err !== 1'b0) begin n_bad++; $display("FAIL reset_tx_err: got %b, expected 0", tx_err); end
      do_reset();
      n_vec++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_idle_grant: got %b, expected 0000", grant); end
   endtask

   task automatic test_single_byte();
      do_reset();
      busy_len = 10;
      load(2, 8'h5A, 1'b1);
      drive();
      repeat (13) step();
      n_vec++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant_held: got %b, expected 0100", grant); end
      step();
      n_vec++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_grant_clear: got %b, expected 0000", grant); end
      repeat (6) step();
      n_vec++;
      if (en_cyc.size() != 1) begin
         n_bad++; $display("FAIL single_en_count: got %0d, expected 1", en_cyc.size());
      end else begin
         n_vec++; if (en_cyc[0] != 2) begin n_bad++; $display("FAIL single_en_cycle: got %0d, expected 2", en_cyc[0]); end
         n_vec++; if (en_dat[0] !== 8'h5A) begin n_bad++; $display("FAIL single_data: got %h, expected 5a", en_dat[0]); end
         n_vec++; if (en_gnt[0] !== 4'b0100) begin n_bad++; $display("FAIL single_en_grant: got %b, expected 0100", en_gnt[0]); end
      end
      n_vec++; if (tx_data !== 8'h5A) begin n_bad++; $display("FAIL single_data_hold: got %h, expected 5a", tx_data); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [7:0] exp_d [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
      do_reset();
      busy_len = 2;
      for (int i = 0; i < 4; i++) load(i, 8'(8'hA0 + i), 1'b1);
      for (int i = 0; i < 4; i++) load(i, 8'(8'hB0 + i), 1'b1);
      drive();
      repeat (52) begin
         step();
         n_vec++; if (!$onehot0(grant)) begin n_bad++; $display("FAIL rr_grant_onehot: got %b at cycle %0d", grant, cyc); end
         n_vec++; if (!$onehot0(req_ready)) begin n_bad++; $display("FAIL rr_ready_onehot: got %b at cycle %0d", req_ready, cyc); end
      end
      n_vec++;
      if (en_cyc.size() != 8) begin
         n_bad++; $display("FAIL rr_count: got %0d bytes, expected 8", en_cyc.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_vec++; if (en_gnt[k] !== exp_g[k]) begin n_bad++; $display("FAIL rr_order[%0d]: got %b, expected %b", k, en_gnt[k], exp_g[k]); end
            n_vec++; if (en_dat[k] !== exp_d[k]) begin n_bad++; $display("FAIL rr_data[%0d]: got %h, expected %h", k, en_dat[k], exp_d[k]); end
         end
      end
   endtask

   task automatic test_packet_lock();
      logic [3:0] exp_g [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
      logic [7:0] exp_d [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
      do_reset();
      busy_len = 2;
      load(1, 8'hA1, 1'b0); load(1, 8'hA2, 1'b0); load(1, 8'hA3, 1'b1);
      drive();
      step();
      load(0, 8'hB0, 1'b1);
      drive();
      for (int c = 1; c < 17; c++) begin
         n_vec++; if (req_ready[0] !== 1'b0) begin n_bad++; $display("FAIL lock_no_ready0: got 1 at cycle %0d, expected 0", cyc); end
         step();
      end
      n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL lock_ready0: got %b, expected 0001", req_ready); end
      n_vec++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL lock_grant0: got %b, expected 0001", grant); end
      repeat (10) step();
      n_vec++;
      if (en_cyc.size() != 4) begin
         n_bad++; $display("FAIL lock_count: got %0d bytes, expected 4", en_cyc.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_vec++; if (en_gnt[k] !== exp_g[k]) begin n_bad++; $display("FAIL lock_owner[%0d]: got %b, expected %b", k, en_gnt[k], exp_g[k]); end
            n_vec++; if (en_dat[k] !== exp_d[k]) begin n_bad++; $display("FAIL lock_data[%0d]: got %h, expected %h", k, en_dat[k], exp_d[k]); end
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      busy_len = 2;
      load(3, 8'hC1, 1'b0); load(3, 8'hC2, 1'b1);
      drive();
      repeat (2) step();
      stall[3] = 1'b1;
      drive();
      repeat (4) step();
      for (int c = 6; c < 20; c++) begin
         n_vec++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL stall_ready: got %b at cycle %0d, expected 1000", req_ready, cyc); end
         n_vec++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL stall_grant: got %b at cycle %0d, expected 1000", grant, cyc); end
         step();
      end
      n_vec++; if (err_cyc.size() != 0) begin n_bad++; $display("FAIL stall_no_err: got %0d errors, expected 0", err_cyc.size()); end
      n_vec++; if (en_cyc.size() != 1) begin n_bad++; $display("FAIL stall_en_count: got %0d, expected 1", en_cyc.size()); end
      stall[3] = 1'b0;
      drive();
      step();
      n_vec++; if (tx_en !== 1'b1) begin n_bad++; $display("FAIL stall_resume_en: got %b, expected 1", tx_en); end
      n_vec++; if (tx_data !== 8'hC2) begin n_bad++; $display("FAIL stall_resume_data: got %h, expected c2", tx_data); end
   endtask

   task automatic test_timeout();
      do_reset();
      busy_len = 0;
      load(2, 8'hD1, 1'b0); load(2, 8'hD2, 1'b1);
      drive();
      repeat (10) step();
      n_vec++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL to_grant_held: got %b, expected 0100", grant); end
      step();
      n_vec++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL to_grant_clear: got %b, expected 0000", grant); end
      repeat (3) step();
      n_vec++;
      if (err_cyc.size() != 2) begin
         n_bad++; $display("FAIL to_err_count: got %0d, expected 2", err_cyc.size());
      end else begin
         n_vec++; if (err_cyc[0] != 6) begin n_bad++; $display("FAIL to_err_cycle0: got %0d, expected 6", err_cyc[0]); end
         n_vec++; if (err_cyc[1] != 11) begin n_bad++; $display("FAIL to_err_cycle1: got %0d, expected 11", err_cyc[1]); end
      end
      n_vec++;
      if (en_cyc.size() != 2) begin
         n_bad++; $display("FAIL to_en_count: got %0d, expected 2", en_cyc.size());
      end else begin
         n_vec++; if (en_cyc[1] != 7) begin n_bad++; $display("FAIL to_en_cycle1: got %0d, expected 7", en_cyc[1]); end
         n_vec++; if (en_dat[1] !== 8'hD2) begin n_bad++; $display("FAIL to_data1: got %h, expected d2", en_dat[1]); end
      end
   endtask

   task automatic test_gap();
      do_reset();
      sel_g = 1'b1;
      busy_len = 2;
      load(0, 8'hE1, 1'b0); load(0, 8'hE2, 1'b1);
      drive();
      step();
      n_vec++; if (g_req_ready !== 4'b0001) begin n_bad++; $display("FAIL gap_first_ready: got %b, expected 0001", g_req_ready); end
      repeat (5) step();
      for (int c = 6; c < 9; c++) begin
         n_vec++; if (g_req_ready !== 4'b0000) begin n_bad++; $display("FAIL gap_idle_ready: got %b at cycle %0d, expected 0000", g_req_ready, cyc); end
         n_vec++; if (g_grant !== 4'b0001) begin n_bad++; $display("FAIL gap_grant_held: got %b at cycle %0d, expected 0001", g_grant, cyc); end
         step();
      end
      n_vec++; if (g_req_ready !== 4'b0001) begin n_bad++; $display("FAIL gap_second_ready: got %b, expected 0001", g_req_ready); end
      repeat (7) step();
      n_vec++; if (g_grant !== 4'b0001) begin n_bad++; $display("FAIL gap_last_grant: got %b, expected 0001", g_grant); end
      step();
      n_vec++; if (g_grant !== 4'b0000) begin n_bad++; $display("FAIL gap_release: got %b, expected 0000", g_grant); end
      n_vec++; if (g_tx_data !== 8'hE2) begin n_bad++; $display("FAIL gap_data: got %h, expected e2", g_tx_data); end
      sel_g = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      busy_len = 10;
      for (int i = 0; i < 4; i++) load(i, 8'(8'hC0 + i), 1'b1);
      drive();
      repeat (20) step();
      n_vec++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL mid_pre_grant: got %b, expected 0010", grant); end
      n_vec++; if (tx_data !== 8'hC1) begin n_bad++; $display("FAIL mid_pre_data: got %h, expected c1", tx_data); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL mid_grant: got %b, expected 0000", grant); end
      n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready: got %b, expected 0000", req_ready); end
      n_vec++; if (tx_en !== 1'b0) begin n_bad++; $display("FAIL mid_tx_en: got %b, expected 0", tx_en); end
      n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL mid_tx_data: got %h, expected 00", tx_data); end
      n_vec++; if (tx_err !== 1'b0) begin n_bad++; $display("FAIL mid_tx_err: got %b, expected 0", tx_err); end
      n_vec++; if (en_cyc.size() != 2) begin n_bad++; $display("FAIL mid_en_count: got %0d, expected 2", en_cyc.size()); end
      do_reset();
      for (int i = 0; i < 4; i++) load(i, 8'(8'hD0 + i), 1'b1);
      drive();
      step();
      n_vec++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL mid_restart_grant: got %b, expected 0001", grant); end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_data  = 32'h0000_0000;
      req_last  = 4'b0000;
      test_reset();
      test_single_byte();
      test_round_robin();
      test_packet_lock();
      test_stall();
      test_timeout();
      test_gap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
